issue2_scoreboard_allocator: RTL and testbench
==============================================

# issue2_scoreboard_allocator

Parametrised dual-issue allocator for the prefetch/ID boundary. It decides each cycle whether the secondary candidate (I2) may issue alongside the primary instruction (PI). The decision covers intra-bundle register hazards and a scoreboard of in-flight long-latency (memory) destinations. A post-flush cooldown and a dual-issue statistics counter make it stateful.

## Interface

Parameters:
- REG_AW, 6: register-id width; the scoreboard holds 2**REG_AW entries.
- MAX_PEND, 4: maximum simultaneously pending long-latency destinations.
- COOLDOWN, 2: cycles I2 allocation is blocked after a flush (0 disables the cooldown).
- I2_MEM_EN, 0: 1 allows I2 to be a long-latency (memory-destination) op; 0 forbids it.

Ports (clock and reset first):
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- di_en_i, input, 1: global dual-issue enable.
- pi_legal_i / i2_legal_i, input, 1 each: mini-decode legality for each slot.
- i2_valid_i, input, 1: the I2 candidate is present.
- pi_ra_used_i, pi_rb_used_i, input, 1 each: PI source-use flags.
- pi_ra_i, pi_rb_i, input, REG_AW each: PI source ids.
- i2_ra_used_i, i2_rb_used_i, i2_rc_used_i, input, 1 each: I2 source-use flags.
- i2_ra_i, i2_rb_i, input, REG_AW each: I2 source ids.
- pi_we_i, i2_we_i, input, 1 each: standard destination write enables.
- pi_wid_i, i2_wid_i, input, REG_AW each: destination ids.
- pi_mem_i, i2_mem_i, input, 1 each: the destination is long-latency (load).
- pi_pinc_i, input, 1: PI writes pi_ra_i as a post-increment second destination.
- issue_accept_i, input, 1: ID consumes the bundle this cycle.
- wb_valid_i, input, 1: long-latency write-back retires.
- wb_id_i, input, REG_AW: id of the retiring write-back.
- flush_i, input, 1: pipeline flush.
- i2_allocate_ok_o, output, 1: I2 may issue with PI. Combinational.
- pi_hazard_o, output, 1: a PI source is pending in the scoreboard. Combinational.
- pend_full_o, output, 1: the pending count equals MAX_PEND.
- di_count_o, output, 32: count of accepted dual issues.

## Operation

- **Scoreboard state.**
  - pend[2**REG_AW] is one bit per register.
  - pend_cnt is an up/down counter of width $clog2(MAX_PEND+1).
- **Setting entries.**
  - On issue_accept_i && pi_we_i && pi_mem_i, set pend[pi_wid_i].
  - On issue_accept_i && i2_allocate_ok_o && i2_we_i && i2_mem_i, set pend[i2_wid_i].
  - Id 0 is never set.
- **Clearing entries.** On wb_valid_i, clear pend[wb_id_i]. Set wins over a same-cycle clear of the same id.
- **Pending count.**
  - pend_cnt tracks the number of set bits; it is net-adjusted when a set and a clear occur in the same cycle.
  - A set of an already-set bit does not increment it.
  - A clear of an unset bit does not decrement it.
- **pi_hazard_o** = (pi_ra_used_i && pend[pi_ra_i]) || (pi_rb_used_i && pend[pi_rb_i]).
- **i2_allocate_ok_o** is the AND of all of the following:
  - di_en_i, i2_valid_i, pi_legal_i, i2_legal_i, !i2_rc_used_i, and cooldown_cnt==0.
  - !pi_hazard_o.
  - For each used I2 source: no match against pi_wid_i when pi_we_i, no match against pi_ra_i when pi_pinc_i, and not pending in pend.
  - I2 destination does not equal pi_wid_i while pi_mem_i && pi_we_i && i2_we_i.
  - If i2_mem_i && i2_we_i: I2_MEM_EN==1, and pend_cnt + (pi_mem_i && pi_we_i) < MAX_PEND.
- **Scoreboard capacity.** The owner of PI issue must stall on a PI load while pend_full_o is high; this block does not check that.
- **Flush.**
  - flush_i loads cooldown_cnt with COOLDOWN.
  - Otherwise cooldown_cnt decrements to 0 and saturates there.
  - Flush does not clear the scoreboard, because in-flight loads still write back.
  - A set in the flush cycle is suppressed.
- **Statistics.** di_count_o increments when issue_accept_i && i2_allocate_ok_o && !flush_i, and wraps at 2**32.

## Timing

- **Reset.** Synchronous; applies when rst_n is low at a rising edge.
  - pend = 0, pend_cnt = 0, cooldown_cnt = 0, di_count_o = 0.
  - Hence pend_full_o = 0 and pi_hazard_o = 0.
  - i2_allocate_ok_o then follows its inputs.
- **Reset precedence.** Reset mid-operation discards pending state. Any later wb_valid_i for a discarded id is a harmless no-op.
- **Latency.**
  - Scoreboard set and clear take effect one cycle after the qualifying edge.
  - A same-cycle write-back does not unblock a dependent source in that cycle; no bypass is provided.
- **Cooldown.** I2 is blocked for exactly COOLDOWN cycles after the flush cycle, plus the flush cycle itself (1 + COOLDOWN cycles total).
- **Output paths.** pend_full_o and di_count_o are registered. i2_allocate_ok_o and pi_hazard_o are combinational from inputs and state.

## Test plan

- **Reset and independent bundle.** Reset, then PI `add x5` and I2 `add x6,x7,x8`, valid, all legal -> i2_allocate_ok_o=1. After accept, di_count_o=1.
- **Intra-bundle RAW.**
  - PI writes x5 and I2 reads x5 -> ok=0.
  - PI post-increment on x10 and I2 reads x10 -> ok=0.
- **Scoreboard lifecycle.**
  - Accept PI load to x9 -> next cycle pend_cnt=1; I2 reading x9 -> ok=0; PI reading x9 -> pi_hazard_o=1.
  - wb_valid_i with wb_id=9 -> one cycle later ok=1.
  - A same-cycle set and clear of x9 -> x9 stays pending.
- **Capacity.**
  - With MAX_PEND=4, issue loads to x1..x4 -> pend_full_o=1.
  - I2 load with I2_MEM_EN=1 -> ok=0.
  - Retire x2 -> pend_full_o=0 the next cycle.
- **Flush cooldown.** With COOLDOWN=2, pulse flush_i while a legal bundle is held -> ok=0 for 3 cycles, then 1. The x9 pending bit survives the flush, and di_count_o does not increment in the flush cycle.
- **Counter wrap.** Force di_count_o to 0xFFFFFFFF, then accept one dual issue -> di_count_o=0.

Source files
------------

// File: rtl/issue2_scoreboard_allocator.sv
// Dual-issue allocator: decides whether I2 may issue alongside PI, tracking
// in-flight long-latency destinations, a post-flush cooldown and a dual-issue count.
module issue2_scoreboard_allocator #(
  parameter int unsigned REG_AW    = 6,
  parameter int unsigned MAX_PEND  = 4,
  parameter int unsigned COOLDOWN  = 2,
  parameter int unsigned I2_MEM_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              di_en_i,
  input  logic              pi_legal_i,
  input  logic              i2_legal_i,
  input  logic              i2_valid_i,
  input  logic              pi_ra_used_i,
  input  logic              pi_rb_used_i,
  input  logic [REG_AW-1:0] pi_ra_i,
  input  logic [REG_AW-1:0] pi_rb_i,
  input  logic              i2_ra_used_i,
  input  logic              i2_rb_used_i,
  input  logic              i2_rc_used_i,
  input  logic [REG_AW-1:0] i2_ra_i,
  input  logic [REG_AW-1:0] i2_rb_i,
  input  logic              pi_we_i,
  input  logic              i2_we_i,
  input  logic [REG_AW-1:0] pi_wid_i,
  input  logic [REG_AW-1:0] i2_wid_i,
  input  logic              pi_mem_i,
  input  logic              i2_mem_i,
  input  logic              pi_pinc_i,
  input  logic              issue_accept_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_id_i,
  input  logic              flush_i,
  output logic              i2_allocate_ok_o,
  output logic              pi_hazard_o,
  output logic              pend_full_o,
  output logic [31:0]       di_count_o
);

  localparam int unsigned NREG = 1 << REG_AW;
  localparam int unsigned CW   = $clog2(MAX_PEND + 1);
  localparam int unsigned CDW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;
  logic [CDW-1:0]  cooldown_q, cooldown_d;
  logic [31:0]     di_count_q, di_count_d;

  logic        ra_blk, rb_blk, waw_blk, mem_blk, pi_load;
  logic        set_pi, set_i2, inc_pi, inc_i2, clr_eff;
  logic [31:0] occ;

  always_comb begin
    pi_hazard_o = (pi_ra_used_i && pend_q[pi_ra_i]) || (pi_rb_used_i && pend_q[pi_rb_i]);
    pi_load     = pi_mem_i && pi_we_i;
    ra_blk  = (pi_we_i && (i2_ra_i == pi_wid_i)) || (pi_pinc_i && (i2_ra_i == pi_ra_i)) ||
              pend_q[i2_ra_i];
    rb_blk  = (pi_we_i && (i2_rb_i == pi_wid_i)) || (pi_pinc_i && (i2_rb_i == pi_ra_i)) ||
              pend_q[i2_rb_i];
    waw_blk = pi_load && i2_we_i && (i2_wid_i == pi_wid_i);
    // Capacity must leave room for a PI load issuing in the same bundle.
    occ     = 32'(pend_cnt_q) + 32'(pi_load);
    mem_blk = i2_mem_i && i2_we_i && ((I2_MEM_EN != 1) || (occ >= MAX_PEND));

    i2_allocate_ok_o = di_en_i && i2_valid_i && pi_legal_i && i2_legal_i && !i2_rc_used_i &&
                       (cooldown_q == '0) && !flush_i && !pi_hazard_o &&
                       !(i2_ra_used_i && ra_blk) && !(i2_rb_used_i && rb_blk) &&
                       !waw_blk && !mem_blk;
  end

  always_comb begin
    set_pi = issue_accept_i && pi_load && !flush_i && (pi_wid_i != '0);
    set_i2 = issue_accept_i && i2_allocate_ok_o && i2_we_i && i2_mem_i && !flush_i &&
             (i2_wid_i != '0);

    pend_d = pend_q;
    if (wb_valid_i) pend_d[wb_id_i] = 1'b0;
    if (set_pi)     pend_d[pi_wid_i] = 1'b1;
    if (set_i2)     pend_d[i2_wid_i] = 1'b1;

    // Count only real 0->1 / 1->0 transitions; a set overriding a clear is no change.
    inc_pi  = set_pi && !pend_q[pi_wid_i];
    inc_i2  = set_i2 && !pend_q[i2_wid_i] && !(set_pi && (pi_wid_i == i2_wid_i));
    clr_eff = wb_valid_i && pend_q[wb_id_i] && !(set_pi && (pi_wid_i == wb_id_i)) &&
              !(set_i2 && (i2_wid_i == wb_id_i));
    pend_cnt_d = pend_cnt_q + CW'(inc_pi) + CW'(inc_i2) - CW'(clr_eff);

    if (flush_i)                 cooldown_d = CDW'(COOLDOWN);
    else if (cooldown_q != '0)   cooldown_d = cooldown_q - 1'b1;
    else                         cooldown_d = cooldown_q;

    di_count_d = di_count_q + 32'(issue_accept_i && i2_allocate_ok_o && !flush_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
      cooldown_q <= '0;
      di_count_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      cooldown_q <= cooldown_d;
      di_count_q <= di_count_d;
    end
  end

  assign pend_full_o = (pend_cnt_q == CW'(MAX_PEND));
  assign di_count_o  = di_count_q;

endmodule

// File: tb/tb_issue2_scoreboard_allocator.sv
// Directed and randomized checks of the dual-issue allocator against a set-based reference model.
module tb_issue2_scoreboard_allocator;

  localparam int unsigned REG_AW    = 6;
  localparam int unsigned MAX_PEND  = 4;
  localparam int unsigned COOLDOWN  = 2;
  localparam int unsigned I2_MEM_EN = 1;
  localparam int unsigned NREG      = 1 << REG_AW;

  logic clk = 1'b0;
  logic rst_n;
  logic di_en, pi_legal, i2_legal, i2_valid;
  logic pi_ra_used, pi_rb_used, i2_ra_used, i2_rb_used, i2_rc_used;
  logic [REG_AW-1:0] pi_ra, pi_rb, i2_ra, i2_rb, pi_wid, i2_wid, wb_id;
  logic pi_we, i2_we, pi_mem, i2_mem, pi_pinc, accept, wb_valid, flush;
  logic ok, hazard, full;
  logic [31:0] count;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          pend_m [NREG];
  logic [31:0] di_m;
  int          cyc = 0;
  int          last_flush = -1000;

  always #5 clk = ~clk;

  issue2_scoreboard_allocator #(
    .REG_AW(REG_AW), .MAX_PEND(MAX_PEND), .COOLDOWN(COOLDOWN), .I2_MEM_EN(I2_MEM_EN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .di_en_i(di_en), .pi_legal_i(pi_legal), .i2_legal_i(i2_legal),
    .i2_valid_i(i2_valid), .pi_ra_used_i(pi_ra_used), .pi_rb_used_i(pi_rb_used),
    .pi_ra_i(pi_ra), .pi_rb_i(pi_rb), .i2_ra_used_i(i2_ra_used), .i2_rb_used_i(i2_rb_used),
    .i2_rc_used_i(i2_rc_used), .i2_ra_i(i2_ra), .i2_rb_i(i2_rb), .pi_we_i(pi_we),
    .i2_we_i(i2_we), .pi_wid_i(pi_wid), .i2_wid_i(i2_wid), .pi_mem_i(pi_mem),
    .i2_mem_i(i2_mem), .pi_pinc_i(pi_pinc), .issue_accept_i(accept), .wb_valid_i(wb_valid),
    .wb_id_i(wb_id), .flush_i(flush), .i2_allocate_ok_o(ok), .pi_hazard_o(hazard),
    .pend_full_o(full), .di_count_o(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pend_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(pend_m[i]);
    return n;
  endfunction

  function automatic bit exp_hazard();
    return (pi_ra_used && pend_m[pi_ra]) || (pi_rb_used && pend_m[pi_rb]);
  endfunction

  function automatic bit src_busy(input logic [REG_AW-1:0] id);
    return (pi_we && id == pi_wid) || (pi_pinc && id == pi_ra) || pend_m[id];
  endfunction

  function automatic bit exp_ok();
    bit b;
    b = di_en && i2_valid && pi_legal && i2_legal && !i2_rc_used && !flush && !exp_hazard();
    if ((cyc - last_flush) <= int'(COOLDOWN)) b = 0;
    if (i2_ra_used && src_busy(i2_ra)) b = 0;
    if (i2_rb_used && src_busy(i2_rb)) b = 0;
    if (pi_mem && pi_we && i2_we && i2_wid == pi_wid) b = 0;
    if (i2_mem && i2_we &&
        (I2_MEM_EN != 1 || pend_count() + int'(pi_mem && pi_we) >= int'(MAX_PEND))) b = 0;
    return b;
  endfunction

  task automatic idle();
    di_en = 0; pi_legal = 0; i2_legal = 0; i2_valid = 0;
    pi_ra_used = 0; pi_rb_used = 0; i2_ra_used = 0; i2_rb_used = 0; i2_rc_used = 0;
    pi_ra = '0; pi_rb = '0; i2_ra = '0; i2_rb = '0; pi_wid = '0; i2_wid = '0; wb_id = '0;
    pi_we = 0; i2_we = 0; pi_mem = 0; i2_mem = 0; pi_pinc = 0; accept = 0;
    wb_valid = 0; flush = 0;
  endtask

  task automatic indep_bundle();
    idle();
    di_en = 1; pi_legal = 1; i2_legal = 1; i2_valid = 1;
    pi_we = 1; pi_wid = 6'd5;
    i2_we = 1; i2_wid = 6'd6; i2_ra_used = 1; i2_ra = 6'd7; i2_rb_used = 1; i2_rb = 6'd8;
  endtask

  // compare all outputs with the model, clock once, advance the model
  task automatic tick();
    bit e;
    e = exp_ok();
    check("ok", ok, e);
    check("hazard", hazard, exp_hazard());
    check("full", full, pend_count() == int'(MAX_PEND));
    check("count", count, di_m);
    @(posedge clk);
    if (accept && e) di_m = di_m + 1;
    if (wb_valid) pend_m[wb_id] = 0;
    if (!flush) begin
      if (accept && pi_we && pi_mem && pi_wid != 0) pend_m[pi_wid] = 1;
      if (accept && e && i2_we && i2_mem && i2_wid != 0) pend_m[i2_wid] = 1;
    end
    if (flush) last_flush = cyc;
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < NREG; i++) pend_m[i] = 0;
    di_m = '0;
    last_flush = -1000;
    cyc += 2;
    #1;
    rst_n = 1;
  endtask

  task automatic pi_load(input logic [REG_AW-1:0] id);
    idle();
    accept = 1; pi_we = 1; pi_mem = 1; pi_wid = id;
    #1; tick();
  endtask

  task automatic retire(input logic [REG_AW-1:0] id);
    idle();
    wb_valid = 1; wb_id = id;
    #1; tick();
  endtask

  initial begin
    reset_dut();
    #1;
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_hazard", hazard, 0);

    // independent bundle
    indep_bundle(); accept = 1;
    #1; check("indep_ok", ok, 1);
    tick();
    check("indep_count", count, 1);

    // intra-bundle RAW and post-increment
    indep_bundle(); i2_ra = 6'd5;
    #1; check("raw_ok", ok, 0); tick();
    indep_bundle(); pi_pinc = 1; pi_ra = 6'd10; i2_rb = 6'd10;
    #1; check("pinc_ok", ok, 0); tick();

    // scoreboard lifecycle
    pi_load(6'd9);
    indep_bundle(); i2_ra = 6'd9;
    #1; check("sb_i2_ok", ok, 0); tick();
    idle(); pi_ra_used = 1; pi_ra = 6'd9;
    #1; check("sb_pi_haz", hazard, 1); tick();
    indep_bundle(); i2_ra = 6'd9; wb_valid = 1; wb_id = 6'd9;
    #1; check("sb_wb_nobypass", ok, 0); tick();
    indep_bundle(); i2_ra = 6'd9;
    #1; check("sb_after_wb", ok, 1); tick();
    pi_load(6'd9);
    idle(); accept = 1; pi_we = 1; pi_mem = 1; pi_wid = 6'd9; wb_valid = 1; wb_id = 6'd9;
    #1; tick();
    idle(); pi_ra_used = 1; pi_ra = 6'd9;
    #1; check("set_wins", hazard, 1); tick();
    retire(6'd9);

    // capacity
    for (int i = 1; i <= 4; i++) pi_load(6'(i));
    check("cap_full", full, 1);
    indep_bundle(); i2_mem = 1; i2_wid = 6'd20;
    #1; check("cap_i2_load", ok, 0); tick();
    retire(6'd2);
    check("cap_not_full", full, 0);
    indep_bundle(); i2_mem = 1; i2_wid = 6'd20;
    #1; check("cap_i2_room", ok, 1); tick();
    indep_bundle(); i2_mem = 1; i2_wid = 6'd20; pi_mem = 1;
    #1; check("cap_pi_plus_i2", ok, 0); tick();
    retire(6'd20);

    // flush cooldown
    pi_load(6'd9);
    indep_bundle(); accept = 1; flush = 1;
    #1; check("flush_cycle", ok, 0); tick();
    flush = 0;
    for (int i = 0; i < int'(COOLDOWN); i++) begin
      #1; check("cooldown", ok, 0); tick();
    end
    #1; check("cool_done", ok, 1); tick();
    idle(); pi_ra_used = 1; pi_ra = 6'd9;
    #1; check("flush_keeps_pend", hazard, 1); tick();

    // counter wrap
    indep_bundle(); accept = 1;
    force dut.di_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.di_count_q;
    di_m = 32'hFFFF_FFFF;
    tick();
    check("wrap", count, 0);

    // reset discards pending state; stale write-back is harmless
    reset_dut();
    retire(6'd9);
    idle(); pi_ra_used = 1; pi_ra = 6'd9; pi_rb_used = 1; pi_rb = 6'd3;
    #1; check("rst_discard", hazard, 0); tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      di_en = ($urandom_range(0, 9) != 0);
      pi_legal = ($urandom_range(0, 9) != 0);
      i2_legal = ($urandom_range(0, 9) != 0);
      i2_valid = ($urandom_range(0, 4) != 0);
      pi_ra_used = $urandom_range(0, 1); pi_rb_used = $urandom_range(0, 1);
      i2_ra_used = $urandom_range(0, 1); i2_rb_used = $urandom_range(0, 1);
      i2_rc_used = ($urandom_range(0, 9) == 0);
      pi_ra = 6'($urandom_range(0, 15)); pi_rb = 6'($urandom_range(0, 15));
      i2_ra = 6'($urandom_range(0, 15)); i2_rb = 6'($urandom_range(0, 15));
      pi_wid = 6'($urandom_range(0, 15)); i2_wid = 6'($urandom_range(0, 15));
      pi_we = $urandom_range(0, 1); i2_we = $urandom_range(0, 1);
      pi_mem = ($urandom_range(0, 3) == 0) && (pend_count() < int'(MAX_PEND));
      i2_mem = ($urandom_range(0, 2) == 0);
      pi_pinc = ($urandom_range(0, 7) == 0);
      accept = ($urandom_range(0, 3) != 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_id = 6'($urandom_range(0, 15));
      flush = ($urandom_range(0, 39) == 0);
      #1; tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
